// File: rtl/div_seq_pkg.sv
// Shared FSM encodings and control constants for the div_seq divide sequencer.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0] work_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [2*DATA_W:0] work_o
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W:0]   trial;

    always_comb begin
        shifted = work_i << 1;
        trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_i};
        work_o  = shifted;
        // A clear borrow bit means the partial remainder covered the divisor.
        if (!trial[DATA_W]) begin
            work_o = {trial, shifted[DATA_W-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer with pipeline stall request.
// Define DIV_ANNUL_EN to let annul_i abort an in-flight divide and block acceptance.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stall_req_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);
`ifdef DIV_ANNUL_EN
    localparam logic ANNUL_EN = 1'b1;
`else
    localparam logic ANNUL_EN = 1'b0;
`endif

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W:0]   work_q, work_d, work_step;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
    logic                annul_act;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? DATA_W'(-x) : x;
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? ((~x) + DATA_W'(1)) : x;
    endfunction

    assign annul_act   = annul_i & ANNUL_EN;
    assign stall_req_o = start_i & ~ready_q;
    assign ready_o     = ready_q;
    assign result_o    = result_q;

    div_step #(.DATA_W(DATA_W)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (work_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i == DIV_START && !annul_act) begin
                    neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                    neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    if (opdata2_i == '0) begin
                        state_d = DIV_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        work_d    = {{(DATA_W+1){1'b0}},
                                     signed_div_i ? abs_val(opdata1_i) : opdata1_i};
                        divisor_d = signed_div_i ? abs_val(opdata2_i) : opdata2_i;
                    end
                end
            end
            DIV_ZERO: begin
                result_d = '0;
                if (annul_act) begin
                    state_d = DIV_FREE;
                    ready_d = DIV_RESULT_NOT_READY;
                end else begin
                    state_d = DIV_END;
                    ready_d = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_act) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (cnt_q == LAST_STEP) begin
                    // Magnitudes are done; restore signs as the result is registered.
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                    result_d = {neg_if(neg_rem_q, work_q[2*DATA_W-1:DATA_W]),
                                neg_if(neg_quo_q, work_q[DATA_W-1:0])};
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded at accept.
    always_ff @(posedge clk) begin
        work_q    <= work_d;
        divisor_q <= divisor_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed scoreboard bench for div_seq: expected results queued at request, checked at ready.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int          checks;
    int          failures;
    logic [63:0] sb[$];

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stall_req_o  (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold start_i until ready; exp_edge is the edge index (accept = 0) after which ready rises.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp_res, input int exp_edge,
                           input int hold_n);
        int          edges;
        int          stall_n;
        logic [63:0] exp_v;
        logic [63:0] first;
        sb.push_back(exp_res);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        tick();
        edges   = 0;
        stall_n = 0;
        opdata1_i = 32'h0;
        opdata2_i = 32'h0;
        while (!ready_o && edges < 60) begin
            if (stall_req_o) stall_n++;
            tick();
            edges++;
        end
        exp_v = sb.pop_front();
        check({tag, "_ready_edge"}, edges, exp_edge);
        check({tag, "_stall_cycles"}, stall_n, exp_edge);
        check({tag, "_stall_low_at_ready"}, stall_req_o, 1'b0);
        check({tag, "_result"}, result_o, exp_v);
        first = result_o;
        for (int i = 0; i < hold_n; i++) begin
            tick();
            check({tag, "_hold_result"}, result_o, first);
            check({tag, "_hold_ready"}, ready_o, 1'b1);
        end
        start_i = 1'b0;
        tick();
        check({tag, "_clear_ready"}, ready_o, 1'b0);
        check({tag, "_clear_result"}, result_o, 64'h0);
    endtask

    // start_i drops after drop_edge; annul_i optionally pulses in that same cycle.
    task automatic run_drop(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input int drop_edge, input logic use_annul,
                            input logic [63:0] exp_res, input logic exp_ready);
        int          edges;
        logic [63:0] exp_v;
        sb.push_back(exp_res);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        tick();
        edges = 0;
        while (!ready_o && edges < 40) begin
            if (edges == drop_edge) begin
                start_i = 1'b0;
                annul_i = use_annul;
            end else begin
                annul_i = 1'b0;
            end
            tick();
            edges++;
        end
        annul_i = 1'b0;
        exp_v = sb.pop_front();
        check({tag, "_ready"}, ready_o, exp_ready);
        if (exp_ready) check({tag, "_ready_edge"}, edges, 33);
        check({tag, "_result"}, result_o, exp_v);
        start_i = 1'b0;
        tick();
        check({tag, "_after_ready"}, ready_o, 1'b0);
        check({tag, "_after_result"}, result_o, 64'h0);
    endtask

    initial begin
        int seen;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        annul_i      = 1'b0;
        repeat (3) tick();
        check("reset_ready", ready_o, 1'b0);
        check("reset_result", result_o, 64'h0);
        check("reset_stall", stall_req_o, 1'b0);
        rst = 1'b0;
        tick();

        run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 5);
        tick();
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        tick();
        run_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 33, 0);
        tick();
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, 0);
        tick();
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 0);
        tick();
        run_div("u5_0", 32'd5, 32'd0, 1'b0, 64'h0, 1, 0);
        tick();
        run_div("s5_0", 32'd5, 32'd0, 1'b1, 64'h0, 1, 2);
        tick();

`ifdef DIV_ANNUL_EN
        run_drop("annul", 32'hFFFF_FFFF, 32'd3, 1'b0, 10, 1'b1, 64'h0, 1'b0);
`else
        run_drop("annul", 32'hFFFF_FFFF, 32'd3, 1'b0, 10, 1'b1, {32'h0, 32'h5555_5555}, 1'b1);
`endif
        tick();

        // Reset while the divide is in flight must leave nothing behind.
        opdata1_i    = 32'd123;
        opdata2_i    = 32'd4;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        tick();
        repeat (20) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        check("midrst_ready", ready_o, 1'b0);
        check("midrst_result", result_o, 64'h0);
        check("midrst_stall", stall_req_o, 1'b0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (ready_o) seen++;
        end
        check("midrst_no_ready", seen, 0);
        run_div("u9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);
        tick();

        run_drop("pulse", 32'hFFFF_FF9C, 32'd7, 1'b1, 3, 1'b0, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
